// File: rtl/spi_mem_arbiter_if.sv
// SPI command/response and local host bus between the SPI slave, the host and the memory arbiter.
interface spi_mem_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic [9:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [7:0]           host_wdata;
  logic                 host_gnt;
  logic [7:0]           host_rdata;
  logic                 host_rvalid;
  logic                 spi_ovf;

  modport slave (
    input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata,
    output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, spi_ovf
  );

  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata,
    input  tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, spi_ovf
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Decodes SPI command words into accesses on a single-port byte RAM shared
// round-robin with a local host port.
module spi_mem_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  spi_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SPI_OP, HOST_OP} state_t;
  typedef enum logic {SIDE_HOST, SIDE_SPI} side_t;

  state_t               state, state_nxt;
  side_t                last;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 pend_valid;
  logic                 pend_rd;
  logic [7:0]           pend_data;
  logic [7:0]           mem [MEM_DEPTH];

  logic [1:0] opcode;
  logic [7:0] payload;
  logic       mem_cmd;
  logic       pend_take;
  logic       pend_load;

  assign opcode    = bus.rx_data[9:8];
  assign payload   = bus.rx_data[7:0];
  // Opcodes 01 and 11 touch the RAM; bit 1 separates read from write.
  assign mem_cmd   = bus.rx_valid && opcode[0];
  assign pend_take = (state == SPI_OP);
  assign pend_load = mem_cmd && (!pend_valid || pend_take);

  assign bus.host_gnt = (state == HOST_OP);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pend_valid && bus.host_req)
          state_nxt = (last == SIDE_HOST) ? SPI_OP : HOST_OP;
        else if (pend_valid)
          state_nxt = SPI_OP;
        else if (bus.host_req)
          state_nxt = HOST_OP;
      end
      SPI_OP:  state_nxt = IDLE;
      HOST_OP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= SIDE_HOST;
    end else begin
      state <= state_nxt;
      if (state == SPI_OP)  last <= SIDE_SPI;
      if (state == HOST_OP) last <= SIDE_HOST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr         <= '0;
      rd_addr         <= '0;
      pend_valid      <= 1'b0;
      pend_rd         <= 1'b0;
      pend_data       <= '0;
      bus.spi_ovf     <= 1'b0;
      bus.tx_data     <= '0;
      bus.tx_valid    <= 1'b0;
      bus.host_rdata  <= '0;
      bus.host_rvalid <= 1'b0;
    end else begin
      if (bus.rx_valid && opcode == 2'b00) wr_addr <= payload;
      if (bus.rx_valid && opcode == 2'b10) rd_addr <= payload;

      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_rd    <= opcode[1];
        pend_data  <= payload;
      end else if (pend_take) begin
        pend_valid <= 1'b0;
      end
      if (mem_cmd && !pend_load) bus.spi_ovf <= 1'b1;

      bus.tx_valid <= pend_take && pend_rd;
      if (pend_take && pend_rd) bus.tx_data <= mem[rd_addr];

      bus.host_rvalid <= (state == HOST_OP) && !bus.host_we;
      if (state == HOST_OP && !bus.host_we) bus.host_rdata <= mem[bus.host_addr];
    end
  end

  // NOTE: the RAM array has no reset; clearing it would turn it into a bank of
  // flops instead of a RAM macro, and its contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (state == SPI_OP && !pend_rd)
      mem[wr_addr] <= pend_data;
    else if (state == HOST_OP && bus.host_we)
      mem[bus.host_addr] <= bus.host_wdata;
  end

endmodule
